// File: rtl/imem_responder.sv
`timescale 1ns/1ps
// Instruction memory responder: fixed-latency word reads over valid/ready,
// in-order response FIFO with credit-based request throttling, backdoor load.
module imem_responder #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = 32'h01000000,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY = 2,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [AWIDTH-1:0] req_addr_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [AWIDTH-1:0] rsp_addr_o,
  output logic [DWIDTH-1:0] rsp_insn_o,
  output logic              rsp_err_o,
  input  logic              load_en_i,
  input  logic [AWIDTH-1:0] load_addr_i,
  input  logic [DWIDTH-1:0] load_data_i
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [AWIDTH-1:0] LIMIT = AWIDTH'(4 * DEPTH_WORDS);
  localparam logic [PW-1:0] PLAST = PW'(RSP_DEPTH - 1);
  localparam logic [CW-1:0] CMAX = CW'(RSP_DEPTH);

  // Addresses below BASEADDR wrap to a huge offset and fail the range test.
  function automatic logic bad_addr(input logic [AWIDTH-1:0] a);
    logic [AWIDTH-1:0] off;
    off = a - BASEADDR;
    return (a[1:0] != 2'b00) || (off >= LIMIT);
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [AWIDTH-1:0] a);
    logic [AWIDTH-1:0] off;
    off = a - BASEADDR;
    return off[IW+1:2];
  endfunction

  logic [DWIDTH-1:0] mem [DEPTH_WORDS];

  logic              accept;
  logic              pop;
  logic              push;
  logic              req_err;
  logic [IW-1:0]     req_idx;
  logic [CW-1:0]     outstanding;

  logic [LATENCY-1:0] pv;
  logic [AWIDTH-1:0]  pa [LATENCY];
  logic [DWIDTH-1:0]  pd [LATENCY];
  logic               pe [LATENCY];

  logic [AWIDTH-1:0] fa [RSP_DEPTH];
  logic [DWIDTH-1:0] fd [RSP_DEPTH];
  logic              fe [RSP_DEPTH];
  logic [PW-1:0]     wp;
  logic [PW-1:0]     rp;
  logic [CW-1:0]     fcnt;

  assign req_err     = bad_addr(req_addr_i);
  assign req_idx     = word_idx(req_addr_i);
  assign req_ready_o = !rst && (outstanding < CMAX);
  assign accept      = req_valid_i && req_ready_o;
  assign rsp_valid_o = (fcnt != '0);
  assign pop         = rsp_valid_o && rsp_ready_i;
  assign push        = pv[LATENCY-1];

  assign rsp_addr_o = rsp_valid_o ? fa[rp] : '0;
  assign rsp_insn_o = rsp_valid_o ? fd[rp] : '0;
  assign rsp_err_o  = rsp_valid_o ? fe[rp] : 1'b0;

  always_ff @(posedge clk) begin
    if (load_en_i && !bad_addr(load_addr_i))
      mem[word_idx(load_addr_i)] <= load_data_i;
  end

  // Slots never stall: credit for the FIFO was taken at accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pa[i] <= '0;
        pd[i] <= '0;
        pe[i] <= 1'b0;
      end
    end else begin
      pv[0] <= accept;
      pa[0] <= req_addr_i;
      pe[0] <= req_err;
      pd[0] <= req_err ? '0 : mem[req_idx];
      for (int i = 1; i < LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
        pd[i] <= pd[i-1];
        pe[i] <= pe[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fa[wp] <= pa[LATENCY-1];
      fd[wp] <= pd[LATENCY-1];
      fe[wp] <= pe[LATENCY-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp          <= '0;
      rp          <= '0;
      fcnt        <= '0;
      outstanding <= '0;
    end else begin
      if (push)
        wp <= (wp == PLAST) ? '0 : wp + 1'b1;
      if (pop)
        rp <= (rp == PLAST) ? '0 : rp + 1'b1;
      unique case ({push, pop})
        2'b10:   fcnt <= fcnt + 1'b1;
        2'b01:   fcnt <= fcnt - 1'b1;
        default: fcnt <= fcnt;
      endcase
      unique case ({accept, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
`timescale 1ns/1ps
// Directed bench for imem_responder: table of fetch vectors plus
// backpressure, same-cycle backdoor write and mid-flight reset sequences.
module tb_imem_responder;

  localparam logic [31:0] BASE = 32'h01000000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_addr;
  logic [31:0] rsp_insn;
  logic        rsp_err;
  logic        load_en = 1'b0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;

  always #5 clk = ~clk;

  imem_responder dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_addr_o(rsp_addr), .rsp_insn_o(rsp_insn),
    .rsp_err_o(rsp_err),
    .load_en_i(load_en), .load_addr_i(load_addr),
    .load_data_i(load_data)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] insn;
    logic        err;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] insn;
    logic        err;
  } vec_t;

  rsp_t  rq[$];
  int    aq[$];
  rsp_t  mon;
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  vec_t  vt[7];
  logic [31:0] w[6];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      mon.addr = rsp_addr;
      mon.insn = rsp_insn;
      mon.err  = rsp_err;
      mon.cyc  = cyc;
      rq.push_back(mon);
    end
    if (req_valid && req_ready)
      aq.push_back(cyc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic send(input logic [31:0] a);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_addr = a;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=%h required=ready", a);
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    int k;
    k = 0;
    while (rq.size() < n && k < 100) begin
      tick();
      k++;
    end
    check("rsp_count", rq.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int sent;
    logic [31:0] h_addr;
    logic [31:0] h_insn;

    w[0] = 32'h00000013;
    w[1] = 32'h00100093;
    w[2] = 32'h00200113;
    w[3] = 32'h00308193;
    w[4] = 32'h00400213;
    w[5] = 32'h11111111;
    vt[0] = '{BASE,                w[0], 1'b0};
    vt[1] = '{BASE + 32'h4,        w[1], 1'b0};
    vt[2] = '{BASE + 32'h8,        w[2], 1'b0};
    vt[3] = '{BASE + 32'hC,        w[3], 1'b0};
    vt[4] = '{32'h01000002,        32'h0, 1'b1};
    vt[5] = '{32'h01001000,        32'h0, 1'b1};
    vt[6] = '{32'h00FFFFFC,        32'h0, 1'b1};

    // asynchronous reset state
    #1 rst = 1'b1;
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_addr", rsp_addr, 0);
    check("rst_rsp_insn", rsp_insn, 0);
    check("rst_rsp_err", rsp_err, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rel_req_ready", req_ready, 1);

    for (int i = 0; i < 6; i++)
      load(BASE + 32'(4 * i), w[i]);

    // table vectors, back-to-back
    rsp_ready = 1'b1;
    rq.delete();
    aq.delete();
    for (int i = 0; i < 7; i++)
      send(vt[i].addr);
    wait_rsp(7);
    if (rq.size() == 7) begin
      for (int i = 0; i < 7; i++) begin
        check($sformatf("vec%0d_addr", i), rq[i].addr, vt[i].addr);
        check($sformatf("vec%0d_insn", i), rq[i].insn, vt[i].insn);
        check($sformatf("vec%0d_err", i), 32'(rq[i].err), 32'(vt[i].err));
      end
      check("latency", rq[0].cyc, aq[0] + 1 + 2);
      for (int i = 1; i < 4; i++)
        check($sformatf("thru%0d", i), rq[i].cyc, rq[0].cyc + i);
    end

    // backpressure: six offered, four credits
    rsp_ready = 1'b0;
    rq.delete();
    aq.delete();
    sent = 0;
    for (int c = 0; c < 10; c++) begin
      req_valid = (sent < 6);
      req_addr = BASE + 32'(4 * sent);
      if (req_valid && req_ready) sent++;
      tick();
    end
    check("bp_accepted", sent, 4);
    check("bp_req_ready", req_ready, 0);
    check("bp_rsp_valid", rsp_valid, 1);
    check("bp_head_addr", rsp_addr, BASE);
    check("bp_head_insn", rsp_insn, w[0]);
    h_addr = rsp_addr;
    h_insn = rsp_insn;
    repeat (3) tick();
    check("bp_hold_addr", rsp_addr, h_addr);
    check("bp_hold_insn", rsp_insn, h_insn);
    check("bp_hold_ready", req_ready, 0);
    rsp_ready = 1'b1;
    for (int c = 0; c < 40 && (sent < 6 || rq.size() < 6); c++) begin
      req_valid = (sent < 6);
      req_addr = BASE + 32'(4 * sent);
      if (req_valid && req_ready) sent++;
      tick();
    end
    req_valid = 1'b0;
    check("bp_rsp_count", rq.size(), 6);
    check("bp_acc_count", aq.size(), 6);
    if (rq.size() == 6 && aq.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        check($sformatf("bp%0d_addr", i), rq[i].addr, BASE + 32'(4 * i));
        check($sformatf("bp%0d_insn", i), rq[i].insn, w[i]);
      end
      check("bp_credit_cycle", aq[4], rq[0].cyc + 1);
    end

    // backdoor write and read of the same word in one cycle
    rq.delete();
    check("wr_ready", req_ready, 1);
    load_en = 1'b1;
    load_addr = BASE + 32'h14;
    load_data = 32'hDEADBEEF;
    req_valid = 1'b1;
    req_addr = BASE + 32'h14;
    tick();
    load_en = 1'b0;
    req_valid = 1'b0;
    send(BASE + 32'h14);
    wait_rsp(2);
    if (rq.size() == 2) begin
      check("wr_old", rq[0].insn, 32'h11111111);
      check("wr_new", rq[1].insn, 32'hDEADBEEF);
    end

    // reset with three requests in flight
    rsp_ready = 1'b0;
    rq.delete();
    send(BASE);
    send(BASE + 32'h4);
    send(BASE + 32'h8);
    check("pre_rst_valid", rsp_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_addr", rsp_addr, 0);
    check("mid_rst_insn", rsp_insn, 0);
    check("mid_rst_ready", req_ready, 0);
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    check("post_rst_ready", req_ready, 1);
    rsp_ready = 1'b1;
    repeat (6) tick();
    check("no_stale", rq.size(), 0);
    check("no_stale_valid", rsp_valid, 0);
    send(BASE);
    send(BASE + 32'h14);
    wait_rsp(2);
    if (rq.size() == 2) begin
      check("mem_kept0", rq[0].insn, w[0]);
      check("mem_kept5", rq[1].insn, 32'hDEADBEEF);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
